// File: rtl/pulse_meter_pkg.sv
// Shared types and default sizing for the pulse_meter block.
package pulse_meter_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Input synchronizer, optional 3-sample deglitch filter (PULSE_METER_FILTER_EN)
// and registered edge detector producing one-cycle EDGE_POS / EDGE_NEG pulses.
module sync_edge_det
    import pulse_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic CLK,
    input  logic RST,
    input  logic T_IN,
    output logic EDGE_POS,
    output logic EDGE_NEG
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic                   lvl_d;
    logic                   lvl_q;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], T_IN};
        end
    end

`ifdef PULSE_METER_FILTER_EN
    // Level follows the synchronizer only once three consecutive samples agree.
    logic [1:0] hist_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[0], sync_lvl};
        end
    end

    assign lvl_d = (sync_lvl == hist_q[0] && hist_q[0] == hist_q[1]) ? sync_lvl : lvl_q;
`else
    assign lvl_d = sync_lvl;
`endif

    // lvl_q doubles as the edge flop; the pulses are registered so they never overlap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lvl_q    <= 1'b0;
            EDGE_POS <= 1'b0;
            EDGE_NEG <= 1'b0;
        end else begin
            lvl_q    <= lvl_d;
            EDGE_POS <= lvl_d & ~lvl_q;
            EDGE_NEG <= ~lvl_d & lvl_q;
        end
    end

endmodule

// File: rtl/pulse_meter.sv
// Measures high time and rise-to-rise period of an asynchronous pulse train.
// Define PULSE_METER_FILTER_EN to add a 3-sample deglitch filter on the input.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             T_IN,
    output logic [CNT_W-1:0] HIGH_CNT,
    output logic [CNT_W-1:0] PERIOD_CNT,
    output logic             VALID,
    output logic             OVF,
    output logic             EDGE_POS,
    output logic             EDGE_NEG
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] pend;
    logic [CNT_W-1:0] pend_n;
    logic             load;
    logic             ovf_set;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_det (
        .CLK     (CLK),
        .RST     (RST),
        .T_IN    (T_IN),
        .EDGE_POS(EDGE_POS),
        .EDGE_NEG(EDGE_NEG)
    );

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_ONE;
        pend_n  = pend;
        load    = 1'b0;
        ovf_set = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (EDGE_POS) begin
                    state_n = HIGH;
                    cnt_n   = CNT_ONE;
                end
            end
            HIGH: begin
                // Saturation wins over a coincident edge; the measurement is abandoned.
                if (cnt == CNT_MAX) begin
                    ovf_set = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (EDGE_NEG) begin
                    state_n = LOW;
                    pend_n  = cnt;
                end
            end
            LOW: begin
                if (cnt == CNT_MAX) begin
                    ovf_set = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (EDGE_POS) begin
                    state_n = HIGH;
                    cnt_n   = CNT_ONE;
                    load    = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            pend       <= '0;
            HIGH_CNT   <= '0;
            PERIOD_CNT <= '0;
            VALID      <= 1'b0;
            OVF        <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pend  <= pend_n;
            VALID <= load;
            if (load) begin
                PERIOD_CNT <= cnt;
                HIGH_CNT   <= pend;
            end
            if (ovf_set) begin
                OVF <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: a 16-bit instance for measurement/reset cases
// and a 4-bit instance for saturation and falling-edge-only cases.
module tb_pulse_meter;
    import pulse_meter_pkg::*;

`ifdef PULSE_METER_FILTER_EN
    localparam int EDGE_LAT     = 5;
    localparam int GLITCH_EDGES = 0;
`else
    localparam int EDGE_LAT     = 3;
    localparam int GLITCH_EDGES = 1;
`endif

    logic        CLK = 1'b0;
    logic        rst, t_in, rst4, t_in4;
    logic [15:0] high_cnt, period_cnt;
    logic        valid, ovf, edge_pos, edge_neg;
    logic [3:0]  high_cnt4, period_cnt4;
    logic        valid4, ovf4, edge_pos4, edge_neg4;

    int checks = 0;
    int errors = 0;

    logic [15:0] hq[$];
    logic [15:0] pq[$];
    logic [3:0]  h4q[$];
    logic [3:0]  p4q[$];
    int pos_cnt = 0, neg_cnt = 0, both_cnt = 0;
    int neg4_cnt = 0, both4_cnt = 0;

    always #5 CLK = ~CLK;

    pulse_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
        .CLK       (CLK),
        .RST       (rst),
        .T_IN      (t_in),
        .HIGH_CNT  (high_cnt),
        .PERIOD_CNT(period_cnt),
        .VALID     (valid),
        .OVF       (ovf),
        .EDGE_POS  (edge_pos),
        .EDGE_NEG  (edge_neg)
    );

    pulse_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .CLK       (CLK),
        .RST       (rst4),
        .T_IN      (t_in4),
        .HIGH_CNT  (high_cnt4),
        .PERIOD_CNT(period_cnt4),
        .VALID     (valid4),
        .OVF       (ovf4),
        .EDGE_POS  (edge_pos4),
        .EDGE_NEG  (edge_neg4)
    );

    // Record every VALID and edge pulse, sampled mid-cycle.
    always @(negedge CLK) begin
        if (valid) begin
            hq.push_back(high_cnt);
            pq.push_back(period_cnt);
        end
        if (valid4) begin
            h4q.push_back(high_cnt4);
            p4q.push_back(period_cnt4);
        end
        if (edge_pos) pos_cnt++;
        if (edge_neg) neg_cnt++;
        if (edge_pos && edge_neg) both_cnt++;
        if (edge_neg4) neg4_cnt++;
        if (edge_pos4 && edge_neg4) both4_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit found;
        int pos0, neg0, v0;

        rst = 1'b1; rst4 = 1'b1; t_in = 1'b0; t_in4 = 1'b0;
        tick(3);
        check("rst_high_cnt", high_cnt, 0);
        check("rst_period_cnt", period_cnt, 0);
        check("rst_valid", valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_edge_pos", edge_pos, 0);
        check("rst_edge_neg", edge_neg, 0);
        check("rst_state", dut.state, IDLE);
        rst = 1'b0; rst4 = 1'b0;
        tick(2);

        // 10 high / 10 low for 5 periods, measuring rising-edge latency on the first.
        t_in = 1'b1;
        n = 0; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            n++;
            if (edge_pos) found = 1;
        end
        check("edge_pos_latency", n, EDGE_LAT);
        tick(10 - n);
        t_in = 1'b0;
        tick(10);
        for (int p = 0; p < 4; p++) begin
            t_in = 1'b1; tick(10);
            t_in = 1'b0; tick(10);
        end
        check("sq10_valid_count", hq.size(), 4);
        for (int i = 0; i < hq.size(); i++) begin
            check("sq10_period", pq[i], 20);
            check("sq10_high", hq[i], 10);
        end

        // 3 high / 13 low: two measurements, then a 1-cycle reset while in LOW.
        rst = 1'b1; tick(2); rst = 1'b0; tick(2);
        hq.delete(); pq.delete();
        for (int p = 0; p < 3; p++) begin
            t_in = 1'b1; tick(3);
            t_in = 1'b0; tick(13);
        end
        check("p16_valid_count", hq.size(), 2);
        for (int i = 0; i < hq.size(); i++) begin
            check("p16_period", pq[i], 16);
            check("p16_high", hq[i], 3);
        end
        check("p16_state_low", dut.state, LOW);
        rst = 1'b1; tick(1);
        check("midrst_high_cnt", high_cnt, 0);
        check("midrst_period_cnt", period_cnt, 0);
        check("midrst_valid", valid, 0);
        check("midrst_ovf", ovf, 0);
        check("midrst_edges", {edge_pos, edge_neg}, 0);
        check("midrst_state", dut.state, IDLE);
        rst = 1'b0;
        hq.delete(); pq.delete();
        t_in = 1'b1; tick(3); t_in = 1'b0; tick(13);
        check("arm_only_no_valid", hq.size(), 0);
        t_in = 1'b1; tick(3); t_in = 1'b0; tick(13);
        check("second_rise_valid", hq.size(), 1);
        if (hq.size() > 0) begin
            check("second_rise_period", pq[0], 16);
            check("second_rise_high", hq[0], 3);
        end

        // A 2-cycle glitch passes unfiltered but is removed by the deglitch stage.
        pos0 = pos_cnt; neg0 = neg_cnt;
        t_in = 1'b1; tick(2); t_in = 1'b0; tick(12);
        check("glitch_pos_edges", pos_cnt - pos0, GLITCH_EDGES);
        check("glitch_neg_edges", neg_cnt - neg0, GLITCH_EDGES);
        check("no_coincident_edges", both_cnt, 0);

        // 4-bit instance: two 3/5 periods, then hold high until saturation.
        for (int p = 0; p < 2; p++) begin
            t_in4 = 1'b1; tick(3);
            t_in4 = 1'b0; tick(5);
        end
        t_in4 = 1'b1;
        n = 0; found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1);
            n++;
            if (ovf4) found = 1;
        end
        check("ovf_latency", n, EDGE_LAT + 16);
        check("ovf_state_idle", dut4.state, IDLE);
        check("ovf_valid_count", h4q.size(), 2);
        for (int i = 0; i < h4q.size(); i++) begin
            check("w4_period", p4q[i], 8);
            check("w4_high", h4q[i], 3);
        end
        tick(5);
        check("ovf_sticky", ovf4, 1);
        check("ovf_high_held", high_cnt4, 3);
        check("ovf_period_held", period_cnt4, 8);

        // Falling edge only, starting from IDLE.
        neg0 = neg4_cnt; v0 = h4q.size();
        t_in4 = 1'b0; tick(EDGE_LAT + 4);
        check("idle_fall_edge_neg", neg4_cnt - neg0, 1);
        check("idle_fall_state", dut4.state, IDLE);
        check("idle_fall_no_valid", h4q.size() - v0, 0);
        check("idle_fall_ovf_kept", ovf4, 1);
        check("no_coincident_edges4", both4_cnt, 0);
        rst4 = 1'b1; tick(1);
        check("ovf_cleared_by_rst", ovf4, 0);
        rst4 = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
